// File: rtl/instr_encoder_if.sv
// Request and instruction-stream bundle of the TSC-ISA instruction encoder.
// master = request producer / word consumer, slave = the encoder.
interface instr_encoder_if;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_op;
    logic [1:0]  req_rs;
    logic [1:0]  req_rt;
    logic [1:0]  req_rd;
    logic [15:0] req_imm;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic        err;
    logic        halted;

    modport master (
        output req_valid, req_op, req_rs, req_rt, req_rd, req_imm, instr_ready,
        input  req_ready, instr_valid, instr, err, halted
    );

    modport slave (
        input  req_valid, req_op, req_rs, req_rt, req_rd, req_imm, instr_ready,
        output req_ready, instr_valid, instr, err, halted
    );
endinterface

// File: rtl/instr_encoder.sv
// TSC-ISA instruction encoder: symbolic requests in, packed 16-bit words out
// through a small FIFO; range-checks immediates and expands LDI into LHI+ORI.
module instr_encoder #(
    parameter int DEPTH = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    instr_encoder_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    localparam logic [3:0] OP_BNE = 4'd0;
    localparam logic [3:0] OP_BEQ = 4'd1;
    localparam logic [3:0] OP_BGZ = 4'd2;
    localparam logic [3:0] OP_BLZ = 4'd3;
    localparam logic [3:0] OP_ADI = 4'd4;
    localparam logic [3:0] OP_ORI = 4'd5;
    localparam logic [3:0] OP_LHI = 4'd6;
    localparam logic [3:0] OP_LWD = 4'd7;
    localparam logic [3:0] OP_SWD = 4'd8;
    localparam logic [3:0] OP_JMP = 4'd9;
    localparam logic [3:0] OP_JAL = 4'd10;
    localparam logic [3:0] OP_ALU = 4'd15;

    localparam logic [5:0] FN_JPR = 6'd25;
    localparam logic [5:0] FN_JRL = 6'd26;
    localparam logic [5:0] FN_WWD = 6'd28;
    localparam logic [5:0] FN_HLT = 6'd29;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXPAND,
        S_HALT
    } state_e;

    state_e        state_q, state_d;
    logic [15:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [15:0]   pend_q, pend_d;
    logic          err_q, err_d;
    logic          halted_q, halted_d;

    logic [1:0]  rs, rt, rd;
    logic [15:0] imm;
    logic        imm_s8_ok, imm_z8_ok, imm_z12_ok;
    logic [15:0] enc_word, enc_ori;
    logic        enc_ok, enc_two, enc_hlt;

    logic        fifo_full, accept, pop, push;
    logic [15:0] push_word;

    assign rs  = bus.req_rs;
    assign rt  = bus.req_rt;
    assign rd  = bus.req_rd;
    assign imm = bus.req_imm;

    // Signed fields must sign-extend from bit 7; unsigned ones must fit their width.
    assign imm_s8_ok  = (imm[15:7] == 9'h000) || (imm[15:7] == 9'h1FF);
    assign imm_z8_ok  = (imm[15:8] == 8'h00);
    assign imm_z12_ok = (imm[15:12] == 4'h0);

    always_comb begin
        enc_word = 16'h0000;
        enc_ori  = 16'h0000;
        enc_ok   = 1'b0;
        enc_two  = 1'b0;
        enc_hlt  = 1'b0;
        case (bus.req_op)
            5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7: begin
                enc_word = {OP_ALU, rs, rt, rd, 3'b000, bus.req_op[2:0]};
                enc_ok   = 1'b1;
            end
            5'd8: begin
                enc_word = {OP_ADI, rs, rt, imm[7:0]};
                enc_ok   = imm_s8_ok;
            end
            5'd9: begin
                enc_word = {OP_ORI, rs, rt, imm[7:0]};
                enc_ok   = imm_z8_ok;
            end
            5'd10: begin
                enc_word = {OP_LHI, rs, rt, imm[7:0]};
                enc_ok   = imm_z8_ok;
            end
            5'd11: begin
                enc_word = {OP_LWD, rs, rt, imm[7:0]};
                enc_ok   = imm_s8_ok;
            end
            5'd12: begin
                enc_word = {OP_SWD, rs, rt, imm[7:0]};
                enc_ok   = imm_s8_ok;
            end
            5'd13: begin
                enc_word = {OP_BNE, rs, rt, imm[7:0]};
                enc_ok   = imm_s8_ok;
            end
            5'd14: begin
                enc_word = {OP_BEQ, rs, rt, imm[7:0]};
                enc_ok   = imm_s8_ok;
            end
            5'd15: begin
                enc_word = {OP_BGZ, rs, rt, imm[7:0]};
                enc_ok   = imm_s8_ok;
            end
            5'd16: begin
                enc_word = {OP_BLZ, rs, rt, imm[7:0]};
                enc_ok   = imm_s8_ok;
            end
            5'd17: begin
                enc_word = {OP_JMP, imm[11:0]};
                enc_ok   = imm_z12_ok;
            end
            5'd18: begin
                enc_word = {OP_JAL, imm[11:0]};
                enc_ok   = imm_z12_ok;
            end
            5'd19: begin
                enc_word = {OP_ALU, rs, 2'b00, 2'b00, FN_JPR};
                enc_ok   = 1'b1;
            end
            5'd20: begin
                enc_word = {OP_ALU, rs, 2'b00, 2'b00, FN_JRL};
                enc_ok   = 1'b1;
            end
            5'd21: begin
                enc_word = {OP_ALU, rs, 2'b00, 2'b00, FN_WWD};
                enc_ok   = 1'b1;
            end
            5'd22: begin
                enc_word = {OP_ALU, 2'b00, 2'b00, 2'b00, FN_HLT};
                enc_ok   = 1'b1;
                enc_hlt  = 1'b1;
            end
            5'd23: begin
                // LDI: LHI loads the high byte; ORI is skipped when the low byte is zero.
                enc_word = {OP_LHI, 2'b00, rt, imm[15:8]};
                enc_ori  = {OP_ORI, rt, rt, imm[7:0]};
                enc_ok   = 1'b1;
                enc_two  = (imm[7:0] != 8'h00);
            end
            default: begin
                enc_ok = 1'b0;
            end
        endcase
    end

    assign fifo_full     = (count_q == FULL_CNT);
    assign bus.req_ready = !rst_i && (state_q == S_IDLE) && !fifo_full;
    assign accept        = bus.req_valid && bus.req_ready;
    assign pop           = bus.instr_valid && bus.instr_ready;

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        push      = 1'b0;
        push_word = enc_word;
        err_d     = 1'b0;
        halted_d  = halted_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (!enc_ok) begin
                        err_d = 1'b1;
                    end else begin
                        push = 1'b1;
                        if (enc_two) begin
                            state_d = S_EXPAND;
                            pend_d  = enc_ori;
                        end
                        if (enc_hlt) begin
                            state_d  = S_HALT;
                            halted_d = 1'b1;
                        end
                    end
                end
            end
            S_EXPAND: begin
                // A same-cycle pop does not free a slot for this push.
                if (!fifo_full) begin
                    push      = 1'b1;
                    push_word = pend_q;
                    state_d   = S_IDLE;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    assign rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    assign count_d  = count_q + CW'(push) - CW'(pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            pend_q   <= 16'h0000;
            err_q    <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            pend_q   <= pend_d;
            err_q    <= err_d;
            halted_q <= halted_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_word;
        end
    end

    assign bus.instr_valid = (count_q != '0);
    assign bus.instr       = bus.instr_valid ? mem_q[rd_ptr_q] : 16'h0000;
    assign bus.err         = err_q;
    assign bus.halted      = halted_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Randomized and directed bench for instr_encoder against a queue-level
// reference model of the encoder, its LDI expansion and its output FIFO.
module tb_instr_encoder;
    localparam int DEPTH = 4;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    instr_encoder_if bus ();

    instr_encoder #(.DEPTH(DEPTH)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    // Reference model state
    logic [15:0] mq[$];
    logic [15:0] mpend[$];
    bit          mhalted = 1'b0;
    bit          merr    = 1'b0;

    int itab[9] = '{4, 5, 6, 7, 8, 0, 1, 2, 3};
    int ftab[4] = '{25, 26, 28, 29};

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void tb_encode(input int op, input int rs, input int rt, input int rd,
                                      input int imm, output logic [15:0] w0,
                                      output logic [15:0] w1, output int nw,
                                      output bit bad, output bit hlt);
        w0 = 16'h0; w1 = 16'h0; nw = 1; bad = 1'b0; hlt = 1'b0;
        if (op < 8) begin
            w0 = 16'(61440 + rs * 1024 + rt * 256 + rd * 64 + op);
        end else if (op <= 16) begin
            w0 = 16'(itab[op - 8] * 4096 + rs * 1024 + rt * 256 + imm % 256);
            if (op == 9 || op == 10) bad = (imm > 255);
            else bad = !(imm < 128 || imm >= 65408);
        end else if (op <= 18) begin
            w0  = 16'(((op == 17) ? 9 : 10) * 4096 + imm % 4096);
            bad = (imm > 4095);
        end else if (op <= 22) begin
            w0  = 16'(61440 + ((op == 22) ? 0 : rs * 1024) + ftab[op - 19]);
            hlt = (op == 22);
        end else if (op == 23) begin
            w0 = 16'(6 * 4096 + rt * 256 + imm / 256);
            if (imm % 256 != 0) begin
                nw = 2;
                w1 = 16'(5 * 4096 + rt * 1024 + rt * 256 + imm % 256);
            end
        end else begin
            bad = 1'b1;
        end
    endfunction

    task automatic model_reset();
        mq.delete();
        mpend.delete();
        mhalted = 1'b0;
        merr    = 1'b0;
    endtask

    // One cycle: drive at negedge, check settled outputs, advance model, cross the edge.
    task automatic step(input bit v, input int op, input int rs, input int rt, input int rd,
                        input int imm, input bit rdy);
        logic [15:0] w0, w1;
        int nw;
        bit bad, hlt, exp_ready, full_b, pop, acc;
        bus.req_valid   = v;
        bus.req_op      = 5'(op);
        bus.req_rs      = 2'(rs);
        bus.req_rt      = 2'(rt);
        bus.req_rd      = 2'(rd);
        bus.req_imm     = 16'(imm);
        bus.instr_ready = rdy;
        #1;
        exp_ready = !mhalted && (mpend.size() == 0) && (mq.size() < DEPTH);
        chk("req_ready", int'(bus.req_ready), int'(exp_ready));
        chk("instr_valid", int'(bus.instr_valid), int'(mq.size() != 0));
        chk("instr", int'(bus.instr), (mq.size() != 0) ? int'(mq[0]) : 0);
        chk("err", int'(bus.err), int'(merr));
        chk("halted", int'(bus.halted), int'(mhalted));
        full_b = (mq.size() == DEPTH);
        pop    = (mq.size() != 0) && rdy;
        acc    = v && exp_ready;
        merr   = 1'b0;
        if (pop) void'(mq.pop_front());
        if (mpend.size() != 0) begin
            if (!full_b) mq.push_back(mpend.pop_front());
        end else if (acc) begin
            tb_encode(op, rs, rt, rd, imm, w0, w1, nw, bad, hlt);
            if (bad) begin
                merr = 1'b1;
            end else begin
                mq.push_back(w0);
                if (nw == 2) mpend.push_back(w1);
                if (hlt) mhalted = 1'b1;
            end
        end
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, 0, 0, rdy);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int op, imm, sel;
        bus.req_valid = 1'b0; bus.req_op = '0; bus.req_rs = '0; bus.req_rt = '0;
        bus.req_rd = '0; bus.req_imm = '0; bus.instr_ready = 1'b0;

        // Reset state
        @(negedge clk_i); @(negedge clk_i);
        #1;
        chk("rst_ready", int'(bus.req_ready), 0);
        chk("rst_valid", int'(bus.instr_valid), 0);
        chk("rst_instr", int'(bus.instr), 0);
        chk("rst_err", int'(bus.err), 0);
        chk("rst_halted", int'(bus.halted), 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        model_reset();

        // Directed encodings with literal expectations
        step(1'b1, 0, 1, 2, 3, 0, 1'b1);          chk("ADD", int'(bus.instr), 16'hF6C0);
        step(1'b1, 19, 2, 0, 0, 0, 1'b1);         chk("JPR", int'(bus.instr), 16'hF819);
        step(1'b1, 20, 2, 0, 0, 0, 1'b1);         chk("JRL", int'(bus.instr), 16'hF81A);
        step(1'b1, 21, 1, 0, 0, 0, 1'b1);         chk("WWD", int'(bus.instr), 16'hF41C);
        step(1'b1, 8, 1, 2, 0, 16'hFFFF, 1'b1);   chk("ADI", int'(bus.instr), 16'h46FF);
        step(1'b1, 8, 1, 2, 0, 16'h0080, 1'b1);
        chk("ADI_rng_err", int'(bus.err), 1);
        chk("ADI_rng_noword", int'(bus.instr_valid), 0);
        step(1'b1, 23, 0, 1, 0, 16'h1234, 1'b1);
        chk("LDI_lhi", int'(bus.instr), 16'h6112);
        chk("LDI_busy", int'(bus.req_ready), 0);
        step(1'b0, 0, 0, 0, 0, 0, 1'b1);          chk("LDI_ori", int'(bus.instr), 16'h5534);
        step(1'b0, 0, 0, 0, 0, 0, 1'b1);
        step(1'b1, 23, 0, 1, 0, 16'h1200, 1'b1);  chk("LDI1_lhi", int'(bus.instr), 16'h6112);
        step(1'b0, 0, 0, 0, 0, 0, 1'b1);
        chk("LDI1_single", int'(bus.instr_valid), 0);
        chk("LDI1_ready", int'(bus.req_ready), 1);

        // Fill FIFO with consumer stalled, then release with a concurrent request
        for (int i = 0; i < DEPTH + 1; i++) step(1'b1, 17, 0, 0, 0, 16'h0ABC, 1'b0);
        chk("full_ready", int'(bus.req_ready), 0);
        chk("full_head", int'(bus.instr), 16'h9ABC);
        for (int i = 0; i < 3; i++) step(1'b1, 17, 0, 0, 0, 16'h0123 + i, 1'b1);
        idle(DEPTH + 2, 1'b1);

        // Randomized traffic (HLT withheld until the end)
        for (int i = 0; i < 600; i++) begin
            op = int'($urandom_range(0, 31));
            if (op == 22) op = 0;
            sel = int'($urandom_range(0, 2));
            if (sel == 0) imm = int'($urandom_range(0, 255));
            else if (sel == 1) imm = int'($urandom_range(16'hFF70, 16'hFFFF));
            else imm = int'($urandom_range(0, 16'hFFFF));
            step(($urandom_range(0, 2) != 0), op, int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), imm,
                 ($urandom_range(0, 3) != 0));
        end
        idle(DEPTH + 3, 1'b1);

        // Reset in the middle of an LDI expansion with the FIFO half full
        step(1'b1, 17, 0, 0, 0, 16'h0555, 1'b0);
        step(1'b1, 23, 0, 2, 0, 16'h1234, 1'b0);
        chk("exp_busy", int'(bus.req_ready), 0);
        rst_i = 1'b1;
        #1;
        chk("midrst_valid", int'(bus.instr_valid), 0);
        chk("midrst_err", int'(bus.err), 0);
        chk("midrst_ready", int'(bus.req_ready), 0);
        model_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
        idle(3, 1'b1);

        // HLT with queued words: they drain, HLT word last, then no more requests
        step(1'b1, 17, 0, 0, 0, 16'h0001, 1'b0);
        step(1'b1, 17, 0, 0, 0, 16'h0002, 1'b0);
        step(1'b1, 22, 0, 0, 0, 0, 1'b0);
        chk("hlt_halted", int'(bus.halted), 1);
        chk("hlt_ready", int'(bus.req_ready), 0);
        step(1'b1, 0, 1, 1, 1, 0, 1'b1);
        step(1'b1, 0, 1, 1, 1, 0, 1'b1);
        chk("hlt_word", int'(bus.instr), 16'hF01D);
        idle(3, 1'b1);
        chk("hlt_drained", int'(bus.instr_valid), 0);
        chk("hlt_stays", int'(bus.req_ready), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
